hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Pipeline sequencing controller paired with the forwarding unit. Detects hazards that forwarding
//   cannot cover (load-use, branch/jr operand not yet forwardable to ID) and drives PC/IF_ID/ID_EX
//   write enables, bubbles and flushes. Owns the multi-cycle MUL/DIV occupancy FSM that freezes the
//   front end while the EX-stage unit is busy. Keeps a saturating stall-cycle performance counter.
// PARAMETERS
//   MD_LATENCY  8   cycles a MUL/DIV occupies EX (>=2); EX is held for MD_LATENCY-1 extra cycles
//   CNT_W       16  width of stall_cycles counter
// PORTS
//   clk           in   1      pipeline clock, all state on rising edge
//   rst_n         in   1      asynchronous, active-low reset
//   ID_Rs         in   5      rs of instruction in ID
//   ID_Rt         in   5      rt of instruction in ID
//   ID_UseRt      in   1      ID instruction reads rt as a source
//   ID_Branch     in   1      ID instruction is beq/bne (compares rs,rt in ID)
//   ID_JumpReg    in   1      ID instruction is jr/jalr (reads rs in ID)
//   ID_Taken      in   1      branch taken / jump resolved in ID this cycle
//   EX_RegWrite   in   1      EX instruction writes a register
//   EX_MemRead    in   1      EX instruction is a load
//   EX_WriteReg   in   5      destination of EX instruction
//   MEM_MemRead   in   1      MEM instruction is a load
//   MEM_WriteReg  in   5      destination of MEM instruction
//   md_start      in   1      EX instruction is MUL/DIV in its first EX cycle
//   PC_Write      out  1      1 = PC updates
//   IF_ID_Write   out  1      1 = IF/ID register loads
//   IF_ID_Flush   out  1      1 = IF/ID loaded with nop
//   ID_EX_Write   out  1      1 = ID/EX register loads
//   ID_EX_Bubble  out  1      1 = ID/EX loaded with nop (control zeroed)
//   EX_MEM_Bubble out  1      1 = EX/MEM loaded with nop
//   md_busy       out  1      FSM in MD_BUSY
//   stall_cycles  out  CNT_W  count of cycles with PC_Write=0, saturating at all-ones
// BEHAVIOUR
//   Register 0 never matches (any compare against WriteReg==0 is false).
//   load_use  = EX_MemRead & (EX_WriteReg==ID_Rs | ID_UseRt & EX_WriteReg==ID_Rt)
//   br_src    = ID_Branch | ID_JumpReg; match on Rs always, on Rt only when ID_Branch
//   br_hazard = br_src & ((EX_RegWrite & EX matches) | (MEM_MemRead & MEM matches))
//   Load feeding a branch therefore stalls 2 cycles (EX then MEM); ALU result in EX stalls 1.
//   FSM states: RUN, MD_BUSY. Counter md_cnt, width clog2(MD_LATENCY).
//     RUN: md_start -> MD_BUSY, md_cnt <= MD_LATENCY-2. Else stay.
//     MD_BUSY: md_cnt==0 -> RUN; else md_cnt-1. md_start ignored in MD_BUSY.
//   Output priority (combinational, zero latency from inputs/state):
//     1 hold = (RUN & md_start) | MD_BUSY: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0,
//       EX_MEM_Bubble=1, ID_EX_Bubble=0, IF_ID_Flush=0. Hazards/ID_Taken ignored.
//     2 stall = load_use | br_hazard: PC_Write=0, IF_ID_Write=0, ID_EX_Write=1, ID_EX_Bubble=1,
//       IF_ID_Flush=0 (ID_Taken ignored: branch not yet valid).
//     3 ID_Taken: all writes 1, IF_ID_Flush=1, bubbles 0.
//     4 else: all writes 1, flush/bubbles 0.
//   Total EX occupancy of a MUL/DIV = MD_LATENCY cycles; it enters MEM on the cycle after RUN returns.
//   stall_cycles increments every cycle PC_Write=0 (rst_n high), holds at 2^CNT_W-1.
//   Reset (async, any time incl. mid MD_BUSY): state=RUN, md_cnt=0, stall_cycles=0, md_busy=0;
//     while rst_n=0: PC_Write=IF_ID_Write=ID_EX_Write=0, IF_ID_Flush=ID_EX_Bubble=EX_MEM_Bubble=1.
//   First rising edge after rst_n rises evaluates normally in RUN.
// TESTING
//   lw $8 in EX, ID add rs=$8 -> 1 cycle: PC_Write=0, ID_EX_Bubble=1; next cycle all writes 1; stall_cycles=1.
//   lw $9 then beq $9,$0 in ID -> 2 stall cycles (EX match, then MEM_MemRead match), then ID_Taken=1 flushes IF/ID.
//   lw to $0 in EX with ID rs=$0 -> no stall; ID_UseRt=0 and rt match only -> no stall.
//   MD_LATENCY=8, md_start pulse -> PC_Write=0, EX_MEM_Bubble=1 for exactly 8 cycles; md_busy high 7; RUN after.
//   md_start coincident with load_use and ID_Taken -> hold wins (no flush); rst_n low in MD_BUSY cycle 3 -> RUN, counters 0 immediately.
//   Force 2^16+5 stall cycles -> stall_cycles saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use and branch-operand stall detection,
// IF/ID flush on resolved branches, MUL/DIV occupancy FSM and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UseRt,
    input  logic             ID_Branch,
    input  logic             ID_JumpReg,
    input  logic             ID_Taken,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteReg,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_WriteReg,
    input  logic             md_start,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Bubble,
    output logic             EX_MEM_Bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int MD_CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t             state_q, state_d;
    logic [MD_CW-1:0]   md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic ex_rs_match, ex_rt_match, mem_rs_match, mem_rt_match;
    logic load_use, br_hazard, hold;

    // Register $0 is hardwired, so a write to it never creates a dependency.
    always_comb begin
        ex_rs_match  = (EX_WriteReg  != 5'd0) && (EX_WriteReg  == ID_Rs);
        ex_rt_match  = (EX_WriteReg  != 5'd0) && (EX_WriteReg  == ID_Rt);
        mem_rs_match = (MEM_WriteReg != 5'd0) && (MEM_WriteReg == ID_Rs);
        mem_rt_match = (MEM_WriteReg != 5'd0) && (MEM_WriteReg == ID_Rt);

        load_use  = EX_MemRead && (ex_rs_match || (ID_UseRt && ex_rt_match));
        br_hazard = (ID_Branch || ID_JumpReg) &&
                    ((EX_RegWrite && (ex_rs_match || (ID_Branch && ex_rt_match))) ||
                     (MEM_MemRead && (mem_rs_match || (ID_Branch && mem_rt_match))));
        hold      = ((state_q == RUN) && md_start) || (state_q == MD_BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            md_cnt_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // The start cycle itself is one of the MD_LATENCY cycles, so BUSY lasts MD_LATENCY-1.
    always_comb begin
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        stall_cycles_d = stall_cycles_q;
        case (state_q)
            RUN: begin
                if (md_start) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_CW'(MD_LATENCY - 2);
                end
            end
            MD_BUSY: begin
                if (md_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - MD_CW'(1);
                end
            end
            default: state_d = RUN;
        endcase
        if (!PC_Write && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Bubble = 1'b0;
        if (!rst_n) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            IF_ID_Flush   = 1'b1;
            ID_EX_Bubble  = 1'b1;
            EX_MEM_Bubble = 1'b1;
        end else if (hold) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
        end else if (load_use || br_hazard) begin
            // A branch waiting on its operands cannot be trusted to flush yet.
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Bubble  = 1'b1;
        end else if (ID_Taken) begin
            IF_ID_Flush   = 1'b1;
        end
    end

    assign md_busy      = (state_q == MD_BUSY);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random cycles,
// all compared against a cycle-count reference model.
module tb_hazard_stall_ctrl;

    localparam int MD_LATENCY = 8;
    localparam int CNT_W      = 16;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_WriteReg = '0, MEM_WriteReg = '0;
    logic ID_UseRt = 0, ID_Branch = 0, ID_JumpReg = 0, ID_Taken = 0;
    logic EX_RegWrite = 0, EX_MemRead = 0, MEM_MemRead = 0, md_start = 0;
    logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, md_busy;
    logic [CNT_W-1:0] stall_cycles;
    logic [6:0] dut_out;

    int n_vec = 0;
    int n_err = 0;
    int m_left = 0;
    int m_stalls = 0;

    hazard_stall_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt), .ID_Branch(ID_Branch),
        .ID_JumpReg(ID_JumpReg), .ID_Taken(ID_Taken),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
        .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg), .md_start(md_start),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_Bubble(EX_MEM_Bubble),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    assign dut_out = {PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, md_busy};

    // Reference model: m_left is how many more cycles the MUL/DIV keeps EX after this one.
    function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [6:0] exp_out();
        logic lu, bh;
        if (!rst_n) return 7'b000_1_1_1_0;
        if (m_left > 0 || md_start) return {6'b000_0_0_1, (m_left > 0) ? 1'b1 : 1'b0};
        lu = EX_MemRead && (hit(EX_WriteReg, ID_Rs) || (ID_UseRt && hit(EX_WriteReg, ID_Rt)));
        bh = 1'b0;
        if (ID_Branch || ID_JumpReg) begin
            if (EX_RegWrite && (hit(EX_WriteReg, ID_Rs) || (ID_Branch && hit(EX_WriteReg, ID_Rt)))) bh = 1'b1;
            if (MEM_MemRead && (hit(MEM_WriteReg, ID_Rs) || (ID_Branch && hit(MEM_WriteReg, ID_Rt)))) bh = 1'b1;
        end
        if (lu || bh) return 7'b001_0_1_0_0;
        if (ID_Taken) return 7'b111_1_0_0_0;
        return 7'b111_0_0_0_0;
    endfunction

    function automatic int exp_cnt();
        return (m_stalls > CNT_MAX) ? CNT_MAX : m_stalls;
    endfunction

    // Advance one clock and update the model; inputs are held across the edge.
    task automatic tick();
        logic [6:0] e;
        logic st;
        e  = exp_out();
        st = md_start;
        @(posedge clk);
        if (rst_n) begin
            if (!e[6]) m_stalls++;
            if (m_left > 0) m_left--;
            else if (st) m_left = MD_LATENCY - 1;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg} = '0;
        {ID_UseRt, ID_Branch, ID_JumpReg, ID_Taken} = '0;
        {EX_RegWrite, EX_MemRead, MEM_MemRead, md_start} = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_left = 0;
        m_stalls = 0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        m_left = 0;
        m_stalls = 0;
        #1;
        n_vec++;
        if (dut_out !== 7'b000_1_1_1_0 || stall_cycles !== '0) begin
            n_err++;
            $display("[TB] FAIL reset: out=%b cnt=%0d, expected out=0001110 cnt=0", dut_out, stall_cycles);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (dut_out !== exp_out() || stall_cycles !== exp_cnt()) begin
            n_err++;
            $display("[TB] FAIL reset_release: out=%b cnt=%0d, expected out=%b cnt=%0d", dut_out, stall_cycles, exp_out(), exp_cnt());
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        clear_inputs();
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 5'd8; ID_Rs = 5'd8; ID_Rt = 5'd3; ID_UseRt = 1;
        #1;
        n_vec++;
        if (dut_out !== 7'b001_0_1_0_0) begin
            n_err++;
            $display("[TB] FAIL load_use_stall: out=%b, expected 0010100", dut_out);
        end
        tick();
        clear_inputs();
        ID_Rs = 5'd8;
        #1;
        n_vec++;
        if (dut_out !== 7'b111_0_0_0_0 || stall_cycles !== 16'd1) begin
            n_err++;
            $display("[TB] FAIL load_use_resume: out=%b cnt=%0d, expected out=1110000 cnt=1", dut_out, stall_cycles);
        end
        tick();
    endtask

    task automatic test_branch_load();
        do_reset();
        clear_inputs();
        ID_Branch = 1; ID_Rs = 5'd9; ID_Rt = 5'd0; ID_UseRt = 1; ID_Taken = 1;
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 5'd9;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 5'd0;
                MEM_MemRead = 1; MEM_WriteReg = 5'd9;
            end
            if (c == 2) begin
                MEM_MemRead = 0; MEM_WriteReg = 5'd0;
            end
            #1;
            n_vec++;
            if (dut_out !== ((c < 2) ? 7'b001_0_1_0_0 : 7'b111_1_0_0_0) || stall_cycles !== 16'(c)) begin
                n_err++;
                $display("[TB] FAIL branch_load c%0d: out=%b cnt=%0d, expected out=%b cnt=%0d", c, dut_out,
                         stall_cycles, (c < 2) ? 7'b001_0_1_0_0 : 7'b111_1_0_0_0, c);
            end
            tick();
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        clear_inputs();
        EX_MemRead = 1; EX_WriteReg = 5'd0; ID_Rs = 5'd0; ID_UseRt = 1;
        #1;
        n_vec++;
        if (dut_out !== 7'b111_0_0_0_0) begin
            n_err++;
            $display("[TB] FAIL reg0_no_stall: out=%b, expected 1110000", dut_out);
        end
        tick();
        EX_WriteReg = 5'd5; ID_Rs = 5'd6; ID_Rt = 5'd5; ID_UseRt = 0;
        #1;
        n_vec++;
        if (dut_out !== 7'b111_0_0_0_0) begin
            n_err++;
            $display("[TB] FAIL rt_unused_no_stall: out=%b, expected 1110000", dut_out);
        end
        tick();
        clear_inputs();
        ID_JumpReg = 1; ID_Rs = 5'd4; ID_Rt = 5'd7; EX_RegWrite = 1; EX_WriteReg = 5'd7;
        #1;
        n_vec++;
        if (dut_out !== 7'b111_0_0_0_0) begin
            n_err++;
            $display("[TB] FAIL jr_rt_no_stall: out=%b, expected 1110000", dut_out);
        end
        tick();
    endtask

    task automatic test_md();
        int pc_low;
        int busy_hi;
        do_reset();
        clear_inputs();
        pc_low = 0;
        busy_hi = 0;
        md_start = 1;
        for (int c = 0; c < MD_LATENCY + 3; c++) begin
            #1;
            if (!PC_Write && EX_MEM_Bubble) pc_low++;
            if (md_busy) busy_hi++;
            n_vec++;
            if (dut_out !== exp_out() || stall_cycles !== exp_cnt()) begin
                n_err++;
                $display("[TB] FAIL md_seq c%0d: out=%b cnt=%0d, expected out=%b cnt=%0d", c, dut_out,
                         stall_cycles, exp_out(), exp_cnt());
            end
            tick();
            md_start = 0;
        end
        n_vec++;
        if (pc_low != MD_LATENCY || busy_hi != MD_LATENCY - 1) begin
            n_err++;
            $display("[TB] FAIL md_occupancy: hold=%0d busy=%0d, expected hold=%0d busy=%0d", pc_low, busy_hi,
                     MD_LATENCY, MD_LATENCY - 1);
        end
    endtask

    task automatic test_md_priority();
        do_reset();
        clear_inputs();
        md_start = 1; ID_Taken = 1; ID_Branch = 1;
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 5'd3; ID_Rs = 5'd3;
        #1;
        n_vec++;
        if (dut_out !== 7'b000_0_0_1_0) begin
            n_err++;
            $display("[TB] FAIL md_priority: out=%b, expected 0000010", dut_out);
        end
        tick();
        md_start = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (dut_out !== exp_out() || stall_cycles !== exp_cnt()) begin
                n_err++;
                $display("[TB] FAIL md_busy_priority c%0d: out=%b cnt=%0d, expected out=%b cnt=%0d", c, dut_out,
                         stall_cycles, exp_out(), exp_cnt());
            end
            tick();
        end
        // Async reset lands mid-cycle while the unit is still busy.
        #2;
        rst_n = 1'b0;
        m_left = 0;
        m_stalls = 0;
        #1;
        n_vec++;
        if (dut_out !== 7'b000_1_1_1_0 || stall_cycles !== '0) begin
            n_err++;
            $display("[TB] FAIL md_async_reset: out=%b cnt=%0d, expected out=0001110 cnt=0", dut_out, stall_cycles);
        end
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (dut_out !== 7'b111_0_0_0_0 || stall_cycles !== '0) begin
            n_err++;
            $display("[TB] FAIL md_after_reset: out=%b cnt=%0d, expected out=1110000 cnt=0", dut_out, stall_cycles);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ID_Rs = 5'($urandom_range(0, 3));
            ID_Rt = 5'($urandom_range(0, 3));
            EX_WriteReg = 5'($urandom_range(0, 3));
            MEM_WriteReg = 5'($urandom_range(0, 3));
            ID_UseRt = 1'($urandom);
            ID_Branch = 1'($urandom);
            ID_JumpReg = 1'($urandom);
            ID_Taken = 1'($urandom);
            EX_RegWrite = 1'($urandom);
            EX_MemRead = 1'($urandom);
            MEM_MemRead = 1'($urandom);
            md_start = ($urandom_range(0, 15) == 0);
            #1;
            n_vec++;
            if (dut_out !== exp_out() || stall_cycles !== exp_cnt()) begin
                n_err++;
                $display("[TB] FAIL random c%0d: out=%b cnt=%0d, expected out=%b cnt=%0d", c, dut_out,
                         stall_cycles, exp_out(), exp_cnt());
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        clear_inputs();
        md_start = 1;
        for (int c = 0; c < CNT_MAX + 6; c++) tick();
        clear_inputs();
        #1;
        n_vec++;
        if (stall_cycles !== 16'hFFFF || stall_cycles !== exp_cnt()) begin
            n_err++;
            $display("[TB] FAIL saturation: cnt=%0h, expected cnt=ffff", stall_cycles);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load();
        test_no_hazard();
        test_md();
        test_md_priority();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
